stopwatch_core: RTL
===================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter: MIN_MAX, default 59, meaning highest minutes value, legal range 1..99.
REQ-002 Port: clk  input  1  system clock; every register updates on its rising edge only.
REQ-003 Port: rst  input  1  reset; synchronous and active-low.
REQ-004 Port: tick_1hz  input  1  one-cycle pulse that advances normal counting.
REQ-005 Port: tick_adj  input  1  one-cycle pulse that steps a field in adjust mode (2 Hz).
REQ-006 Port: sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
REQ-007 Port: adj  input  1  level; 1 = adjust mode.
REQ-008 Port: pse  input  1  debounced level; each rising edge toggles pause.
REQ-009 Port: dir  input  1  count direction: 0 = up, 1 = down.
REQ-010 Port: min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits.
REQ-011 Port: paused  output  1  current pause state.
REQ-012 Port: expired  output  1  high while a down-count is held at 00:00.

Function
REQ-013 Detect pse rising edge with a registered previous value.
REQ-014 An edge toggles paused on the next clock; no other effect.
REQ-015 A tick qualified in cycle N uses the paused value registered before cycle N; a simultaneous pse edge affects only later ticks.
REQ-016 Normal count: adj=0, paused=0, tick_1hz=1 -> time changes by exactly 1 s on the next clock.
REQ-017 Up count: seconds roll 59 -> 00 and carry into minutes.
REQ-018 Up count: MIN_MAX:59 wraps to 00:00.
REQ-019 Down count: seconds 00 -> 59 with a borrow from minutes.
REQ-020 Down count: 00:00 is held, with no wrap.
REQ-021 expired = 1 exactly when dir=1, time=00:00 and a qualified tick has occurred at 00:00; it clears on the clock after the time leaves 00:00, dir goes to 0, or reset.
REQ-022 Adjust mode: adj=1 ignores tick_1hz.
REQ-023 Adjust step: each tick_adj increments the selected field by 1, regardless of paused.
REQ-024 Adjust wrap: seconds 59 -> 00 and minutes MIN_MAX -> 00, with no carry between fields.
REQ-025 Adjust always increments, independent of dir.
REQ-026 Digits are always valid BCD (0..9); tens digits never exceed the field maximum.
REQ-027 Changes to sel, adj or dir take effect on the first clock at which they are sampled; no glitch or extra step results.

Reset
REQ-028 rst=0 at any clock edge forces 00:00, paused=0, expired=0 and clears the pse edge register.
REQ-029 Reset has priority over every tick, edge or mode input in the same cycle.
REQ-030 Reset mid-adjust or mid-count leaves no pending step once rst returns to 1.

Configuration
REQ-031 Macro STOPWATCH_LAP_EN, when defined, adds the following ports:
- lap (input 1)
- lap_min_tens, lap_min_ones, lap_sec_tens, lap_sec_ones (output 4 each)
- lap_valid (output 1)
REQ-032 With the macro defined: each lap rising edge captures the current digits on the next clock and sets lap_valid=1; reset clears all lap outputs to 0.
REQ-033 Without the macro: these ports and registers are absent, and all other behaviour is identical.

Verification
REQ-034 Reset then 60 tick_1hz, dir=0 -> 01:00, expired=0.
REQ-035 MIN_MAX=59, preload 59:59 by adjust, one tick_1hz, dir=0 -> 00:00.
REQ-036 adj=1, sel=1, seconds=59, one tick_adj -> seconds=00 with minutes unchanged; tick_1hz ignored.
REQ-037 dir=1 from 00:02, three tick_1hz -> 00:00, expired=1; a fourth tick -> still 00:00.
REQ-038 pse rising edge coincident with tick_1hz -> that tick counts, paused=1, and the next tick is ignored.
REQ-039 With STOPWATCH_LAP_EN: at 00:37 pulse lap, then two ticks -> lap digits 00:37, lap_valid=1, time 00:39.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch core: MM:SS up/down counter with pause toggle, field adjust mode and expiry flag.
// Optional lap capture registers are built when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       sel,
  input  logic       adj,
  input  logic       pse,
  input  logic       dir,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic [3:0] lap_min_tens,
  output logic [3:0] lap_min_ones,
  output logic [3:0] lap_sec_tens,
  output logic [3:0] lap_sec_ones,
  output logic       lap_valid,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       expired
);

  localparam logic [6:0] MIN_TOP = 7'(MIN_MAX);
  localparam logic [5:0] SEC_TOP = 6'd59;

  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       paused_q;
  logic       expired_q, expired_d;
  logic       pse_q;
  logic       tick_ok;
  logic       zero_q, zero_d;

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    logic [6:0] t;
    t = v % 7'd10;
    return t[3:0];
  endfunction

  // The pause state seen here is the registered one, so a pse edge in the same cycle only affects later ticks.
  assign tick_ok = tick_1hz & ~adj & ~paused_q;
  assign zero_q  = (min_q == '0) && (sec_q == '0);
  assign zero_d  = (min_d == '0) && (sec_d == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    min_d = min_q;
    sec_d = sec_q;
    if (adj) begin
      if (tick_adj) begin
        if (sel) sec_d = (sec_q == SEC_TOP) ? '0 : sec_q + 6'd1;
        else     min_d = (min_q == MIN_TOP) ? '0 : min_q + 7'd1;
      end
    end else if (tick_ok) begin
      if (!dir) begin
        if (sec_q == SEC_TOP) begin
          sec_d = '0;
          min_d = (min_q == MIN_TOP) ? '0 : min_q + 7'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else if (sec_q != '0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != '0) begin
        min_d = min_q - 7'd1;
        sec_d = SEC_TOP;
      end
    end
    // Expiry arms on a down-count tick taken at 00:00 and holds only while the time stays there.
    expired_d = dir & zero_d & (expired_q | (tick_ok & zero_q));
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    if (!rst) begin
      min_q     <= '0;
      sec_q     <= '0;
      paused_q  <= 1'b0;
      expired_q <= 1'b0;
      pse_q     <= 1'b0;
    end else begin
      min_q     <= min_d;
      sec_q     <= sec_d;
      expired_q <= expired_d;
      pse_q     <= pse;
      if (pse && !pse_q) paused_q <= ~paused_q;
    end
  end

  assign min_tens = tens_of(min_q);
  assign min_ones = ones_of(min_q);
  assign sec_tens = tens_of({1'b0, sec_q});
  assign sec_ones = ones_of({1'b0, sec_q});
  assign paused   = paused_q;
  assign expired  = expired_q;

`ifdef STOPWATCH_LAP_EN
  logic [6:0] lap_min_q;
  logic [5:0] lap_sec_q;
  logic       lap_valid_q;
  logic       lap_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_valid_q <= 1'b0;
      lap_prev_q  <= 1'b0;
    end else begin
      lap_prev_q <= lap;
      if (lap && !lap_prev_q) begin
        lap_min_q   <= min_q;
        lap_sec_q   <= sec_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign lap_min_tens = tens_of(lap_min_q);
  assign lap_min_ones = ones_of(lap_min_q);
  assign lap_sec_tens = tens_of({1'b0, lap_sec_q});
  assign lap_sec_ones = ones_of({1'b0, lap_sec_q});
  assign lap_valid    = lap_valid_q;
`endif

endmodule
